// File: rtl/display_write_sequencer.sv
// Purpose: shares the 8-digit display RAM write port between two requesters (A left, B right), BCD-converts and blanks.
// Latency: 20 cycles from the IDLE grant cycle to ack (14 CONV, 4 WRITE, 1 ACK); CLEAR runs 8 writes after reset.
// Backpressure: requests hold until acked; req is sampled only in IDLE, round-robin on ties, so no requester can starve.
module display_write_sequencer #(
  parameter int unsigned BASE_A = 4,
  parameter int unsigned BASE_B = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_a,
  input  logic        req_b,
  input  logic [13:0] val_a,
  input  logic [13:0] val_b,
  input  logic [3:0]  dp_a,
  input  logic [3:0]  dp_b,
  output logic        ack_a,
  output logic        ack_b,
  output logic        sat_a,
  output logic        sat_b,
  output logic        busy,
  output logic        W,
  output logic [2:0]  WADD,
  output logic [5:0]  DIN
);

  typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_CONV, S_WRITE, S_ACK} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;        // clear index, conversion step or digit index
  logic [15:0] bcd_q, bcd_d;
  logic [13:0] bin_q, bin_d;
  logic [3:0]  dp_q, dp_d;
  logic        sel_b_q, sel_b_d;    // requester currently being served is B
  logic        last_b_q, last_b_d;  // last grant went to B
  logic        clamp_q, clamp_d;    // captured value was clamped to 9999
  logic        w_q, w_d;
  logic [2:0]  wadd_q, wadd_d;
  logic [5:0]  din_q, din_d;
  logic        ack_a_q, ack_a_d, ack_b_q, ack_b_d;
  logic        sat_a_q, sat_a_d, sat_b_q, sat_b_d;
  logic        busy_q, busy_d;

  logic        grant_a, grant_b;
  logic [13:0] raw;
  logic [15:0] adj;
  logic [15:0] upper;
  logic [2:0]  base_sel;

  // On a tie the requester not served last wins.
  assign grant_a  = req_a & (~req_b | last_b_q);
  assign grant_b  = req_b & ~grant_a;
  assign base_sel = sel_b_q ? BASE_B[2:0] : BASE_A[2:0];

  // Double-dabble correction: add 3 to every BCD nibble of 5 or more before the shift.
  always_comb begin
    adj = bcd_q;
    for (int k = 0; k < 4; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
    end
  end

  // Next-state and registered-output computation; outputs are aligned to the state they describe.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bcd_d    = bcd_q;
    bin_d    = bin_q;
    dp_d     = dp_q;
    sel_b_d  = sel_b_q;
    last_b_d = last_b_q;
    clamp_d  = clamp_q;
    w_d      = 1'b0;
    wadd_d   = wadd_q;
    din_d    = din_q;
    ack_a_d  = 1'b0;
    ack_b_d  = 1'b0;
    sat_a_d  = sat_a_q;
    sat_b_d  = sat_b_q;
    raw      = grant_b ? val_b : val_a;
    upper    = 16'd0;

    case (state_q)
      S_CLEAR: begin
        if (cnt_q == 4'd8) begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d  = cnt_q + 4'd1;
          w_d    = 1'b1;
          wadd_d = cnt_q[2:0];
          din_d  = 6'd0;
        end
      end
      S_IDLE: begin
        if (grant_a || grant_b) begin
          state_d  = S_CONV;
          cnt_d    = 4'd0;
          sel_b_d  = grant_b;
          last_b_d = grant_b;
          clamp_d  = (raw > 14'd9999);
          bin_d    = (raw > 14'd9999) ? 14'd9999 : raw;
          bcd_d    = 16'd0;
          dp_d     = grant_b ? dp_b : dp_a;
        end
      end
      S_CONV: begin
        bcd_d = {adj[14:0], bin_q[13]};
        bin_d = {bin_q[12:0], 1'b0};
        if (cnt_q == 4'd13) begin
          state_d = S_WRITE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_WRITE: begin
        if (cnt_q == 4'd3) state_d = S_ACK;
        else cnt_d = cnt_q + 4'd1;
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_CLEAR;
        cnt_d   = 4'd0;
      end
    endcase

    // A digit is blanked only when it and every more significant digit are zero; digit 0 always shows.
    if (state_d == S_WRITE) begin
      upper  = bcd_d >> {cnt_d[1:0], 2'b00};
      w_d    = 1'b1;
      wadd_d = base_sel + cnt_d[2:0];
      din_d  = {(cnt_d[1:0] == 2'd0) || (upper != 16'd0), upper[3:0], dp_q[cnt_d[1:0]]};
    end

    if (state_d == S_ACK) begin
      if (sel_b_q) begin
        ack_b_d = 1'b1;
        sat_b_d = clamp_q;
      end else begin
        ack_a_d = 1'b1;
        sat_a_d = clamp_q;
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset restarts the RAM clear and forgets any transfer in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_CLEAR;
      cnt_q    <= 4'd0;
      bcd_q    <= 16'd0;
      bin_q    <= 14'd0;
      dp_q     <= 4'd0;
      sel_b_q  <= 1'b0;
      last_b_q <= 1'b1;
      clamp_q  <= 1'b0;
      w_q      <= 1'b0;
      wadd_q   <= 3'd0;
      din_q    <= 6'd0;
      ack_a_q  <= 1'b0;
      ack_b_q  <= 1'b0;
      sat_a_q  <= 1'b0;
      sat_b_q  <= 1'b0;
      busy_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bcd_q    <= bcd_d;
      bin_q    <= bin_d;
      dp_q     <= dp_d;
      sel_b_q  <= sel_b_d;
      last_b_q <= last_b_d;
      clamp_q  <= clamp_d;
      w_q      <= w_d;
      wadd_q   <= wadd_d;
      din_q    <= din_d;
      ack_a_q  <= ack_a_d;
      ack_b_q  <= ack_b_d;
      sat_a_q  <= sat_a_d;
      sat_b_q  <= sat_b_d;
      busy_q   <= busy_d;
    end
  end

  assign W     = w_q;
  assign WADD  = wadd_q;
  assign DIN   = din_q;
  assign ack_a = ack_a_q;
  assign ack_b = ack_b_q;
  assign sat_a = sat_a_q;
  assign sat_b = sat_b_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_display_write_sequencer.sv
// Bench for display_write_sequencer: directed and random requests against a decimal-arithmetic reference.
// Timing is checked in cycles counted from the IDLE cycle in which a request is first presented.
// Writes and acks are logged by a negedge monitor and compared after each transaction.
module tb_display_write_sequencer;

  localparam int BASE_A = 4;
  localparam int BASE_B = 0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_a = 1'b0, req_b = 1'b0;
  logic [13:0] val_a = '0, val_b = '0;
  logic [3:0]  dp_a = '0, dp_b = '0;
  logic        ack_a, ack_b, sat_a, sat_b, busy, W;
  logic [2:0]  WADD;
  logic [5:0]  DIN;

  display_write_sequencer #(.BASE_A(BASE_A), .BASE_B(BASE_B)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .req_b(req_b),
    .val_a(val_a), .val_b(val_b),
    .dp_a(dp_a), .dp_b(dp_b),
    .ack_a(ack_a), .ack_b(ack_b),
    .sat_a(sat_a), .sat_b(sat_b),
    .busy(busy), .W(W), .WADD(WADD), .DIN(DIN)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; logic [2:0] a; logic [5:0] d; } wr_t;
  wr_t wq[$];
  int  acka_q[$], ackb_q[$];
  int  ncnt = 0;
  int  n_chk = 0, n_fail = 0;
  bit  last_b_m = 1'b1;
  bit  sat_a_m = 1'b0, sat_b_m = 1'b0;

  always @(posedge clk) ncnt <= ncnt + 1;

  always @(negedge clk) begin
    if (W === 1'b1) wq.push_back('{cyc: ncnt, a: WADD, d: DIN});
    if (ack_a === 1'b1) acka_q.push_back(ncnt);
    if (ack_b === 1'b1) ackb_q.push_back(ncnt);
  end

  // Expected RAM word for digit i of value v, using plain decimal arithmetic.
  function automatic logic [5:0] exp_din(input int v, input logic [3:0] dp, input int i);
    int c, p, d;
    bit en;
    c = (v > 9999) ? 9999 : v;
    p = 1;
    for (int j = 0; j < i; j++) p = p * 10;
    d  = (c / p) % 10;
    en = (i == 0) || (c >= p);
    return {en, (en ? 4'(d) : 4'd0), dp[i]};
  endfunction

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy !== 1'b0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, k);
    end
  endtask

  task automatic check_write(input string tag, input int idx, input int cyc, input int addr, input logic [5:0] d);
    n_chk++;
    if (idx >= wq.size()) begin
      n_fail++;
      $display("FAIL %s write%0d: missing, required cyc=%0d addr=%0d din=%h", tag, idx, cyc, addr, d);
    end else if (wq[idx].cyc !== cyc || wq[idx].a !== 3'(addr) || wq[idx].d !== d) begin
      n_fail++;
      $display("FAIL %s write%0d: got cyc=%0d addr=%0d din=%h, required cyc=%0d addr=%0d din=%h",
               tag, idx, wq[idx].cyc, wq[idx].a, wq[idx].d, cyc, addr, d);
    end
  endtask

  task automatic serve(input bit is_b, input int v, input logic [3:0] dp, input string tag);
    int r, got, base;
    bit done;
    wait_idle();
    wq.delete(); acka_q.delete(); ackb_q.delete();
    if (is_b) begin req_b = 1'b1; val_b = v[13:0]; dp_b = dp; end
    else      begin req_a = 1'b1; val_a = v[13:0]; dp_a = dp; end
    r = ncnt; got = -1; done = 1'b0;
    base = is_b ? BASE_B : BASE_A;
    for (int k = 1; k <= 60 && !done; k++) begin
      @(negedge clk);
      if (k == 3) begin
        if (is_b) begin val_b = 14'($urandom); dp_b = 4'($urandom); end
        else      begin val_a = 14'($urandom); dp_a = 4'($urandom); end
      end
      if ((is_b ? ack_b : ack_a) === 1'b1) begin
        got = ncnt; done = 1'b1;
        if (is_b) req_b = 1'b0; else req_a = 1'b0;
      end
    end
    req_a = 1'b0; req_b = 1'b0;
    n_chk++;
    if (got != r + 19) begin
      n_fail++;
      $display("FAIL %s ack_cycle: got %0d, required %0d", tag, got, r + 19);
    end
    n_chk++;
    if (wq.size() != 4) begin
      n_fail++;
      $display("FAIL %s write_count: got %0d, required 4", tag, wq.size());
    end
    for (int i = 0; i < 4; i++) check_write(tag, i, r + 15 + i, base + i, exp_din(v, dp, i));
    n_chk++;
    if ((is_b ? sat_b : sat_a) !== (v > 9999)) begin
      n_fail++;
      $display("FAIL %s sat_served: got %b, required %b", tag, is_b ? sat_b : sat_a, v > 9999);
    end
    n_chk++;
    if ((is_b ? sat_a : sat_b) !== (is_b ? sat_a_m : sat_b_m)) begin
      n_fail++;
      $display("FAIL %s sat_other: got %b, required %b", tag, is_b ? sat_a : sat_b, is_b ? sat_a_m : sat_b_m);
    end
    n_chk++;
    if ((is_b ? acka_q.size() : ackb_q.size()) != 0) begin
      n_fail++;
      $display("FAIL %s other_ack: got %0d pulses, required 0", tag, is_b ? acka_q.size() : ackb_q.size());
    end
    last_b_m = is_b;
    if (is_b) sat_b_m = (v > 9999); else sat_a_m = (v > 9999);
  endtask

  task automatic test_reset();
    int rel;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++;
    if ({W, WADD, DIN, ack_a, ack_b, sat_a, sat_b, busy} !== {1'b0, 3'd0, 6'd0, 4'b0000, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_outputs: got W=%b WADD=%0d DIN=%h ack=%b%b sat=%b%b busy=%b, required 0/0/00/00/00/1",
               W, WADD, DIN, ack_a, ack_b, sat_a, sat_b, busy);
    end
    rst = 1'b0;
    rel = ncnt;
    wq.delete(); acka_q.delete(); ackb_q.delete();
    repeat (9) @(negedge clk);
    n_chk++;
    if (wq.size() != 8) begin
      n_fail++;
      $display("FAIL clear_count: got %0d writes, required 8", wq.size());
    end
    for (int i = 0; i < 8; i++) check_write("clear", i, rel + 1 + i, i, 6'd0);
    n_chk++;
    if (busy !== 1'b0 || W !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_to_idle: got busy=%b W=%b, required busy=0 W=0", busy, W);
    end
    last_b_m = 1'b1; sat_a_m = 1'b0; sat_b_m = 1'b0;
  endtask

  task automatic test_a_basic();
    serve(1'b0, 1234, 4'b0100, "a_1234");
  endtask

  task automatic test_b_small();
    serve(1'b1, 7, 4'b0000, "b_7");
    serve(1'b1, 0, 4'b0000, "b_0");
  endtask

  task automatic test_saturate();
    serve(1'b0, 12000, 4'b0000, "a_12000");
    serve(1'b0, 5, 4'b0000, "a_5");
  endtask

  task automatic test_random();
    for (int n = 0; n < 10; n++) begin
      serve(1'($urandom), int'($urandom_range(0, 16383)), 4'($urandom), "rand");
    end
  endtask

  task automatic test_back_to_back();
    int r, ta, tb, va, vb, fb, sb;
    logic [3:0] pa, pb;
    for (int rep = 0; rep < 3; rep++) begin
      wait_idle();
      wq.delete(); acka_q.delete(); ackb_q.delete();
      va = int'($urandom_range(0, 16383)); vb = int'($urandom_range(0, 16383));
      pa = 4'($urandom); pb = 4'($urandom);
      req_a = 1'b1; val_a = va[13:0]; dp_a = pa;
      req_b = 1'b1; val_b = vb[13:0]; dp_b = pb;
      r = ncnt; ta = -1; tb = -1;
      fb = last_b_m ? 0 : 1;   // the requester not served last goes first
      sb = 1 - fb;
      for (int k = 1; k <= 100 && (ta < 0 || tb < 0); k++) begin
        @(negedge clk);
        if (ack_a === 1'b1) begin ta = ncnt; req_a = 1'b0; end
        if (ack_b === 1'b1) begin tb = ncnt; req_b = 1'b0; end
      end
      req_a = 1'b0; req_b = 1'b0;
      n_chk++;
      if ((fb ? tb : ta) != r + 19 || (sb ? tb : ta) != r + 39) begin
        n_fail++;
        $display("FAIL tie%0d ack_order: got ack_a=%0d ack_b=%0d, required first(%s)=%0d second=%0d",
                 rep, ta, tb, fb ? "B" : "A", r + 19, r + 39);
      end
      for (int i = 0; i < 4; i++)
        check_write("tie_first", i, r + 15 + i, (fb ? BASE_B : BASE_A) + i,
                    exp_din(fb ? vb : va, fb ? pb : pa, i));
      for (int i = 0; i < 4; i++)
        check_write("tie_second", 4 + i, r + 35 + i, (sb ? BASE_B : BASE_A) + i,
                    exp_din(sb ? vb : va, sb ? pb : pa, i));
      last_b_m = (sb == 1);
      sat_a_m = (va > 9999); sat_b_m = (vb > 9999);
      n_chk++;
      if (sat_a !== sat_a_m || sat_b !== sat_b_m) begin
        n_fail++;
        $display("FAIL tie%0d sat: got %b%b, required %b%b", rep, sat_a, sat_b, sat_a_m, sat_b_m);
      end
    end
  endtask

  task automatic test_reset_mid();
    int r, rel, got, v;
    logic [3:0] p;
    wait_idle();
    wq.delete(); acka_q.delete(); ackb_q.delete();
    v = int'($urandom_range(0, 9999)); p = 4'($urandom);
    req_b = 1'b1; val_b = v[13:0]; dp_b = p;
    r = ncnt;
    repeat (17) @(negedge clk);
    n_chk++;
    if (W !== 1'b1 || WADD !== 3'(BASE_B + 2)) begin
      n_fail++;
      $display("FAIL mid_third_write: got W=%b WADD=%0d, required W=1 WADD=%0d", W, WADD, BASE_B + 2);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++;
    if (ackb_q.size() != 0 || W !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_abort: got acks=%0d W=%b busy=%b, required 0/0/1", ackb_q.size(), W, busy);
    end
    rst = 1'b0;
    rel = ncnt;
    wq.delete();
    last_b_m = 1'b1; sat_a_m = 1'b0; sat_b_m = 1'b0;
    got = -1;
    for (int k = 1; k <= 60 && got < 0; k++) begin
      @(negedge clk);
      if (ack_b === 1'b1) begin got = ncnt; req_b = 1'b0; end
    end
    req_b = 1'b0;
    n_chk++;
    if (got != rel + 28) begin
      n_fail++;
      $display("FAIL mid_reserve_ack: got %0d, required %0d", got, rel + 28);
    end
    for (int i = 0; i < 8; i++) check_write("mid_clear", i, rel + 1 + i, i, 6'd0);
    for (int i = 0; i < 4; i++) check_write("mid_reserve", 8 + i, rel + 24 + i, BASE_B + i, exp_din(v, p, i));
    n_chk++;
    if (wq.size() != 12) begin
      n_fail++;
      $display("FAIL mid_write_count: got %0d, required 12", wq.size());
    end
  endtask

  initial begin
    test_reset();
    test_a_basic();
    test_b_small();
    test_saturate();
    test_back_to_back();
    test_random();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/display_write_sequencer.md
# display_write_sequencer

Controller that owns the write port (W, WADD, DIN) of the 8-digit display RAM and shares it between two requesters. Requester A drives the left four digits and requester B the right four. Each request carries a 14-bit binary value and four decimal-point bits. The block arbitrates round-robin, converts the value to BCD with a serial double-dabble, blanks leading zeros, and writes four RAM entries, one per digit.

## Interface
Parameters:
- BASE_A, 4, RAM address of requester A's least-significant digit
- BASE_B, 0, RAM address of requester B's least-significant digit

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- req_a / req_b  in  1  request; held high with val/dp stable until the matching ack
- val_a / val_b  in  14  unsigned binary value to display
- dp_a / dp_b  in  4  decimal points; bit i belongs to digit i (0 = least significant)
- ack_a / ack_b  out  1  one-cycle pulse: that requester's four digits are written
- sat_a / sat_b  out  1  level; the last completed write for that half was clamped
- busy  out  1  high in every state except IDLE
- W  out  1  RAM write enable
- WADD  out  3  RAM write address
- DIN  out  6  RAM data {en, bcd[3:0], dp}; bit 5 = digit enable, bit 0 = decimal point

## Operation
- All outputs are registered.
- Reset values: W=0, WADD=0, DIN=0, ack_a=ack_b=0, sat_a=sat_b=0, busy=1. State is CLEAR with index 0, and last-grant is B.

State machine:
- CLEAR (8 cycles): W=1, WADD=0..7 ascending, DIN=0. Then go to IDLE.
- IDLE: busy=0.
  - If exactly one req is high, grant it.
  - If both are high, grant the requester not granted last, so A wins the first tie after reset.
  - On grant:
    - Capture the value, clamped to 9999 when the input exceeds 9999.
    - Capture the dp bits.
    - Record the saturation flag for that half.
    - Update last-grant.
    - Go to CONV.
- CONV (14 cycles): double-dabble on a 16-bit BCD register plus the 14-bit binary shift register. Each cycle:
  - add 3 to every BCD nibble ≥5;
  - shift the combined register left by 1, with the binary MSB entering BCD bit 0.
  - After 14 cycles the BCD register holds four digits d3..d0.
- WRITE (4 cycles): W=1, WADD=base+i for i=0,1,2,3 (least significant digit first), DIN={en_i, d_i, dp_i}.
  - Leading-zero blanking: en_i=0 when d_i and every more-significant digit are zero and i≠0; otherwise en_i=1.
  - Blanked digits drive bcd=0 but still carry dp_i.
  - Digit 0 is always enabled, so value 0 displays "0".
- ACK (1 cycle): pulse ack of the granted requester, update its sat output, go to IDLE.
- req is sampled only in IDLE. A req still high in the IDLE cycle after ack is treated as a new request.
- A change to val or dp while a request is being served has no effect on the current write; the values are captured at grant.
- The idle requester's sat output is unchanged.

## Timing
- Grant edge → first W=1 cycle is 15 cycles (14 CONV + 1).
- W is high for exactly 4 consecutive cycles per request; ack follows in the next cycle.
- Grant-cycle-to-ack is 20 cycles total, including the IDLE sampling cycle.
- W is never high in IDLE or ACK. WADD and DIN hold their last value when W=0.
- Back-to-back service of A then B (both high): B's grant occurs in the IDLE cycle directly after A's ACK. That gives 20-cycle spacing between ack_a and ack_b.
- Reset mid-operation aborts any CONV or WRITE with no ack. The partially written digits are then overwritten by CLEAR.
- Any req held high through reset is served after CLEAR completes.
- After rst deasserts: 8 CLEAR write cycles, then IDLE (busy=0) on the 9th cycle.

## Test plan
- Reset release, no requests → W=1 for 8 cycles with WADD 0..7 and DIN=0x00, then busy=0, W=0.
- A: val_a=1234, dp_a=0100 → writes 4:0x28, 5:0x26, 6:0x25, 7:0x22; ack_a 20 cycles after grant; sat_a=0.
- B: val_b=7, dp_b=0000 → writes 0:0x2E, 1:0x00, 2:0x00, 3:0x00; val_b=0 → 0:0x20, 1:0x00, 2:0x00, 3:0x00.
- req_a and req_b raised in the same cycle, repeated three times → grant order A, B, A, B, A, B. Each requester's writes use only its own addresses.
- val_a=12000 → digits 9,9,9,9 (4:0x32, 5:0x32, 6:0x32, 7:0x32), sat_a=1 after ack_a. A following val_a=5 → sat_a=0.
- rst asserted on the 3rd WRITE cycle of B → no ack_b; CLEAR rewrites 0..7 with 0x00; the still-high req_b is then re-served with its full 20-cycle sequence.
